lia_sweep_controller: RTL and testbench

//  Sequences the lock-in datapath through a frequency sweep. At each point it programs the
//  NCO phase_increment and waits a settle time. It then integrates N valid I/Q mixer samples
//  and hands the summed I/Q result downstream with a ready/valid handshake.

---
 rtl/lia_ctrl_pkg.sv | 17 +
 rtl/lia_iq_integrator.sv | 98 +++++++++
 rtl/lia_sweep_controller.sv | 165 ++++++++++++++++
 tb/tb_lia_sweep_controller.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lia_ctrl_pkg.sv
// Shared constants for the lock-in sweep controller: default datapath widths and FSM encoding.
// Optional accumulator saturation is selected with the LIA_SWEEP_SAT_EN macro.
package lia_ctrl_pkg;

   localparam int PHASE_WIDTH_DEF = 32;
   localparam int MIXER_WIDTH_DEF = 24;
   localparam int ACC_WIDTH_DEF   = 48;
   localparam int CNT_WIDTH_DEF   = 16;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_SETTLE = 2'd1;
   localparam state_t ST_INTEG  = 2'd2;
   localparam state_t ST_OUTPUT = 2'd3;

endpackage

// File: rtl/lia_iq_integrator.sv
// Dual signed I/Q accumulators with sample counter; wraps by default, saturates with a
// sticky clip flag when LIA_SWEEP_SAT_EN is defined.
module lia_iq_integrator
   import lia_ctrl_pkg::*;
#(
   parameter int MIXER_WIDTH = MIXER_WIDTH_DEF,
   parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
   parameter int CNT_WIDTH   = CNT_WIDTH_DEF
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   en,
   input  logic [MIXER_WIDTH-1:0] i_in,
   input  logic [MIXER_WIDTH-1:0] q_in,
   input  logic [CNT_WIDTH-1:0]   len,
   output logic [ACC_WIDTH-1:0]   acc_i,
   output logic [ACC_WIDTH-1:0]   acc_q,
   output logic                   last
`ifdef LIA_SWEEP_SAT_EN
   ,output logic                  sat_flag
`endif
);

`ifdef LIA_SWEEP_SAT_EN
   // One guard bit above the accumulator exposes signed overflow.
   localparam int SW = ACC_WIDTH + 1;
   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
   logic sat_q, sat_d;
   logic ovf_i, ovf_q;
`else
   localparam int SW = ACC_WIDTH;
`endif
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

   logic [ACC_WIDTH-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [SW-1:0]        sum_i, sum_q;

   always_comb begin
      sum_i   = SW'($signed(acc_i_q)) + SW'($signed(i_in));
      sum_q   = SW'($signed(acc_q_q)) + SW'($signed(q_in));
      acc_i_d = acc_i_q;
      acc_q_d = acc_q_q;
      cnt_d   = cnt_q;
`ifdef LIA_SWEEP_SAT_EN
      ovf_i   = sum_i[ACC_WIDTH] ^ sum_i[ACC_WIDTH-1];
      ovf_q   = sum_q[ACC_WIDTH] ^ sum_q[ACC_WIDTH-1];
      sat_d   = sat_q;
`endif
      if (clr) begin
         acc_i_d = '0;
         acc_q_d = '0;
         cnt_d   = '0;
`ifdef LIA_SWEEP_SAT_EN
         sat_d   = 1'b0;
`endif
      end else if (en) begin
         cnt_d = cnt_q + CNT_ONE;
`ifdef LIA_SWEEP_SAT_EN
         acc_i_d = ovf_i ? (sum_i[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum_i[ACC_WIDTH-1:0];
         acc_q_d = ovf_q ? (sum_q[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum_q[ACC_WIDTH-1:0];
         sat_d   = sat_q | ovf_i | ovf_q;
`else
         acc_i_d = sum_i;
         acc_q_d = sum_q;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_i_q <= '0;
         acc_q_q <= '0;
         cnt_q   <= '0;
`ifdef LIA_SWEEP_SAT_EN
         sat_q   <= 1'b0;
`endif
      end else begin
         acc_i_q <= acc_i_d;
         acc_q_q <= acc_q_d;
         cnt_q   <= cnt_d;
`ifdef LIA_SWEEP_SAT_EN
         sat_q   <= sat_d;
`endif
      end
   end

   // Flags the sample that completes the point, so the FSM leaves INTEG on that same edge.
   assign last  = en && (({1'b0, cnt_q} + (CNT_WIDTH+1)'(1)) == {1'b0, len});
   assign acc_i = acc_i_q;
   assign acc_q = acc_q_q;
`ifdef LIA_SWEEP_SAT_EN
   assign sat_flag = sat_q;
`endif

endmodule

// File: rtl/lia_sweep_controller.sv
// Frequency-sweep sequencer: steps the NCO increment, settles, integrates I/Q, hands results out.
// Define LIA_SWEEP_SAT_EN for saturating accumulators and the sat_flag output.
module lia_sweep_controller
   import lia_ctrl_pkg::*;
#(
   parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
   parameter int MIXER_WIDTH = MIXER_WIDTH_DEF,
   parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
   parameter int CNT_WIDTH   = CNT_WIDTH_DEF
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [PHASE_WIDTH-1:0] f_start,
   input  logic [PHASE_WIDTH-1:0] f_step,
   input  logic [CNT_WIDTH-1:0]   n_points,
   input  logic [CNT_WIDTH-1:0]   settle_cycles,
   input  logic [CNT_WIDTH-1:0]   integ_len,
   output logic [PHASE_WIDTH-1:0] phase_increment,
   input  logic [MIXER_WIDTH-1:0] mixer_i_in,
   input  logic [MIXER_WIDTH-1:0] mixer_q_in,
   input  logic                   mixer_valid,
   output logic [ACC_WIDTH-1:0]   result_i,
   output logic [ACC_WIDTH-1:0]   result_q,
   output logic [CNT_WIDTH-1:0]   result_idx,
   output logic                   result_valid,
   input  logic                   result_ready,
   output logic                   busy,
   output logic                   done
`ifdef LIA_SWEEP_SAT_EN
   ,output logic                  sat_flag
`endif
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

   state_t                 state_q, state_d;
   logic [PHASE_WIDTH-1:0] phase_q, phase_d;
   logic [PHASE_WIDTH-1:0] f_step_q, f_step_d;
   logic [CNT_WIDTH-1:0]   n_points_q, n_points_d;
   logic [CNT_WIDTH-1:0]   settle_q, settle_d;
   logic [CNT_WIDTH-1:0]   integ_len_q, integ_len_d;
   logic [CNT_WIDTH-1:0]   idx_q, idx_d;
   logic [CNT_WIDTH-1:0]   settle_cnt_q, settle_cnt_d;
   logic                   done_q, done_d;

   logic start_ok, start_empty, settle_end, handshake, last_point;
   logic int_clr, int_en, int_last;

   always_comb begin
      start_ok    = start && !abort && (n_points != '0) && (integ_len != '0);
      start_empty = start && !abort && ((n_points == '0) || (integ_len == '0));
      settle_end  = (state_q == ST_SETTLE) && (settle_cnt_q == settle_q);
      handshake   = (state_q == ST_OUTPUT) && result_ready && !abort;
      last_point  = (idx_q == n_points_q - CNT_ONE);
      int_clr     = settle_end && !abort;
      int_en      = (state_q == ST_INTEG) && mixer_valid && !abort;
   end

   lia_iq_integrator #(
      .MIXER_WIDTH (MIXER_WIDTH),
      .ACC_WIDTH   (ACC_WIDTH),
      .CNT_WIDTH   (CNT_WIDTH)
   ) u_integ (
      .clk      (clk),
      .rst      (rst),
      .clr      (int_clr),
      .en       (int_en),
      .i_in     (mixer_i_in),
      .q_in     (mixer_q_in),
      .len      (integ_len_q),
      .acc_i    (result_i),
      .acc_q    (result_q),
      .last     (int_last)
`ifdef LIA_SWEEP_SAT_EN
      ,.sat_flag (sat_flag)
`endif
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start_ok) state_d = ST_SETTLE;
         ST_SETTLE: if (settle_end) state_d = ST_INTEG;
         ST_INTEG:  if (int_last) state_d = ST_OUTPUT;
         ST_OUTPUT: if (handshake) state_d = last_point ? ST_IDLE : ST_SETTLE;
         default:   state_d = ST_IDLE;
      endcase
      if (abort) state_d = ST_IDLE;
   end

   // Config is captured only on a real sweep start and held until the next one.
   always_comb begin
      phase_d      = phase_q;
      f_step_d     = f_step_q;
      n_points_d   = n_points_q;
      settle_d     = settle_q;
      integ_len_d  = integ_len_q;
      idx_d        = idx_q;
      settle_cnt_d = settle_cnt_q;
      done_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            done_d = start_empty;
            if (start_ok) begin
               phase_d      = f_start;
               f_step_d     = f_step;
               n_points_d   = n_points;
               settle_d     = settle_cycles;
               integ_len_d  = integ_len;
               idx_d        = '0;
               settle_cnt_d = '0;
            end
         end
         ST_SETTLE: settle_cnt_d = settle_cnt_q + CNT_ONE;
         ST_OUTPUT: begin
            settle_cnt_d = '0;
            if (handshake) begin
               if (last_point) begin
                  done_d = 1'b1;
               end else begin
                  idx_d   = idx_q + CNT_ONE;
                  phase_d = phase_q + f_step_q;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q      <= '0;
         f_step_q     <= '0;
         n_points_q   <= '0;
         settle_q     <= '0;
         integ_len_q  <= '0;
         idx_q        <= '0;
         settle_cnt_q <= '0;
         done_q       <= 1'b0;
      end else begin
         phase_q      <= phase_d;
         f_step_q     <= f_step_d;
         n_points_q   <= n_points_d;
         settle_q     <= settle_d;
         integ_len_q  <= integ_len_d;
         idx_q        <= idx_d;
         settle_cnt_q <= settle_cnt_d;
         done_q       <= done_d;
      end
   end

   assign phase_increment = phase_q;
   assign result_idx      = idx_q;
   assign result_valid    = (state_q == ST_OUTPUT);
   assign busy            = (state_q != ST_IDLE);
   assign done            = done_q;

endmodule

// File: tb/tb_lia_sweep_controller.sv
// Directed bench for lia_sweep_controller: table of full sweeps plus hand-written corner cases.
// A second instance with 24-bit accumulators covers overflow (wrap or LIA_SWEEP_SAT_EN).
module tb_lia_sweep_controller;

   logic        clk = 1'b0;
   logic        rst, start, abort, mixer_valid, result_ready;
   logic [31:0] f_start, f_step;
   logic [15:0] n_points, settle_cycles, integ_len;
   logic [23:0] mixer_i_in, mixer_q_in;

   logic [31:0] phase_increment, phase24;
   logic [47:0] result_i, result_q;
   logic [23:0] result_i24, result_q24;
   logic [15:0] result_idx, idx24;
   logic        result_valid, busy, done, valid24, busy24, done24;
`ifdef LIA_SWEEP_SAT_EN
   logic        sat_flag, sat_flag24;
`endif

   int errors = 0;
   int checks = 0;
   int cyc, smp;

   always #5 clk = ~clk;

   lia_sweep_controller u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .f_start(f_start), .f_step(f_step), .n_points(n_points),
      .settle_cycles(settle_cycles), .integ_len(integ_len),
      .phase_increment(phase_increment),
      .mixer_i_in(mixer_i_in), .mixer_q_in(mixer_q_in), .mixer_valid(mixer_valid),
      .result_i(result_i), .result_q(result_q), .result_idx(result_idx),
      .result_valid(result_valid), .result_ready(result_ready),
      .busy(busy), .done(done)
`ifdef LIA_SWEEP_SAT_EN
      ,.sat_flag(sat_flag)
`endif
   );

   lia_sweep_controller #(.ACC_WIDTH(24)) u_dut24 (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .f_start(f_start), .f_step(f_step), .n_points(n_points),
      .settle_cycles(settle_cycles), .integ_len(integ_len),
      .phase_increment(phase24),
      .mixer_i_in(mixer_i_in), .mixer_q_in(mixer_q_in), .mixer_valid(mixer_valid),
      .result_i(result_i24), .result_q(result_q24), .result_idx(idx24),
      .result_valid(valid24), .result_ready(result_ready),
      .busy(busy24), .done(done24)
`ifdef LIA_SWEEP_SAT_EN
      ,.sat_flag(sat_flag24)
`endif
   );

   typedef struct {
      logic [15:0] n;
      logic [31:0] fs;
      logic [31:0] st;
      logic [15:0] settle;
      logic [15:0] integ;
      logic [23:0] mi;
      logic [23:0] mq;
      logic [47:0] ei;
      logic [47:0] eq;
      logic [31:0] ph0;
      logic [31:0] ph1;
      logic [31:0] ph2;
   } vec_t;

   vec_t vec[4];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic run_sweep(input vec_t v, input int id);
      int  nres = 0;
      bit  fin = 1'b0;
      logic [31:0] eph;
      @(posedge clk); #1;
      n_points = v.n; f_start = v.fs; f_step = v.st;
      settle_cycles = v.settle; integ_len = v.integ;
      mixer_i_in = v.mi; mixer_q_in = v.mq; mixer_valid = 1'b1;
      result_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 0; c < 2000 && !fin; c++) begin
         @(negedge clk);
         if (result_valid) begin
            eph = (nres == 0) ? v.ph0 : (nres == 1) ? v.ph1 : v.ph2;
            chk($sformatf("vec%0d_i", id),     result_i, v.ei);
            chk($sformatf("vec%0d_q", id),     result_q, v.eq);
            chk($sformatf("vec%0d_idx", id),   result_idx, 64'(nres));
            chk($sformatf("vec%0d_phase", id), phase_increment, eph);
            nres++;
         end
         if (done) fin = 1'b1;
      end
      chk($sformatf("vec%0d_done_seen", id), fin, 1);
      chk($sformatf("vec%0d_nresults", id), 64'(nres), 64'(v.n));
      chk($sformatf("vec%0d_busy_end", id), busy, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", id), done, 0);
   endtask

   task automatic tick_sparse();
      @(posedge clk); #1;
      cyc++;
      if (cyc % 3 == 0) begin
         smp++;
         mixer_valid = 1'b1;
         mixer_i_in  = 24'(smp);
         mixer_q_in  = 24'(-smp);
      end else begin
         mixer_valid = 1'b0;
      end
      @(negedge clk);
   endtask

   initial begin
      bit          seen;
      logic [47:0] e_neg10;
      logic [23:0] e_ovf24;
      e_neg10 = -48'sd10;

      vec[0] = '{16'd3, 32'h0100_0000, 32'h0010_0000, 16'd4, 16'd8, 24'd100, -24'sd50,
                 48'd800, -48'sd400, 32'h0100_0000, 32'h0110_0000, 32'h0120_0000};
      vec[1] = '{16'd2, 32'hFFF0_0000, 32'h0020_0000, 16'd0, 16'd3, -24'sd7, 24'd5,
                 -48'sd21, 48'd15, 32'hFFF0_0000, 32'h0010_0000, 32'h0};
      vec[2] = '{16'd1, 32'h1234_5678, 32'h0, 16'd2, 16'd1, 24'h80_0000, 24'h7F_FFFF,
                 -48'sd8388608, 48'd8388607, 32'h1234_5678, 32'h0, 32'h0};
      vec[3] = '{16'd2, 32'h8000_0000, 32'h8000_0000, 16'd1, 16'd5, 24'd3, -24'sd1,
                 48'd15, -48'sd5, 32'h8000_0000, 32'h0, 32'h0};

      rst = 1'b1; start = 1'b0; abort = 1'b0; mixer_valid = 1'b0; result_ready = 1'b0;
      f_start = '0; f_step = '0; n_points = '0; settle_cycles = '0; integ_len = '0;
      mixer_i_in = '0; mixer_q_in = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_phase", phase_increment, 0);
      chk("rst_result_i", result_i, 0);
      chk("rst_result_q", result_q, 0);
      chk("rst_idx", result_idx, 0);
      chk("rst_valid", result_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);

      for (int k = 0; k < 4; k++) run_sweep(vec[k], k);

      // Sparse valid + backpressure + abort during INTEG of point 1.
      @(posedge clk); #1;
      n_points = 16'd2; f_start = 32'h0040_0000; f_step = 32'h0001_0000;
      settle_cycles = 16'd0; integ_len = 16'd4;
      mixer_valid = 1'b0; result_ready = 1'b0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      cyc = 0; smp = 0; seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         tick_sparse();
         if (result_valid) seen = 1'b1;
      end
      chk("sparse_reached_output", seen, 1);
      chk("sparse_i", result_i, 48'd10);
      chk("sparse_q", result_q, e_neg10);
      for (int k = 0; k < 20; k++) begin
         tick_sparse();
         chk("bp_valid", result_valid, 1);
         chk("bp_i", result_i, 48'd10);
         chk("bp_q", result_q, e_neg10);
         chk("bp_idx", result_idx, 0);
         chk("bp_phase", phase_increment, 32'h0040_0000);
      end
      @(posedge clk); #1 result_ready = 1'b1; mixer_valid = 1'b0;
      @(posedge clk); #1 result_ready = 1'b0;
      @(negedge clk);
      chk("adv_valid", result_valid, 0);
      chk("adv_busy", busy, 1);
      chk("adv_idx", result_idx, 1);
      chk("adv_phase", phase_increment, 32'h0041_0000);
      @(posedge clk);
      @(posedge clk); #1 abort = 1'b1; start = 1'b1;
      @(posedge clk); #1 abort = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_valid", result_valid, 0);
      chk("abort_done", done, 0);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("post_abort_done", done, 0);
         chk("post_abort_valid", result_valid, 0);
         chk("post_abort_busy", busy, 0);
      end
      chk("abort_phase_kept", phase_increment, 32'h0041_0000);

      // Zero-length sweeps.
      @(posedge clk); #1 n_points = 16'd0; integ_len = 16'd4; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("npts0_done", done, 1);
      chk("npts0_busy", busy, 0);
      chk("npts0_valid", result_valid, 0);
      @(negedge clk);
      chk("npts0_done_clear", done, 0);
      @(posedge clk); #1 n_points = 16'd2; integ_len = 16'd0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("integ0_done", done, 1);
      chk("integ0_busy", busy, 0);

      // Mid-sweep reset.
      @(posedge clk); #1;
      n_points = 16'd3; f_start = 32'h0100_0000; settle_cycles = 16'd4; integ_len = 16'd8;
      mixer_valid = 1'b1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_phase", phase_increment, 0);
      chk("midrst_i", result_i, 0);

      // Overflow: 4 x 0x7FFFFF.
      @(posedge clk); #1;
      n_points = 16'd1; f_start = 32'h0; f_step = 32'h0; settle_cycles = 16'd0; integ_len = 16'd4;
      mixer_i_in = 24'h7F_FFFF; mixer_q_in = 24'h0; mixer_valid = 1'b1;
      result_ready = 1'b0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(negedge clk);
         if (valid24) seen = 1'b1;
      end
      chk("ovf_reached_output", seen, 1);
`ifdef LIA_SWEEP_SAT_EN
      e_ovf24 = 24'h7F_FFFF;
      chk("ovf_sat_flag24", sat_flag24, 1);
      chk("ovf_sat_flag48", sat_flag, 0);
`else
      e_ovf24 = 24'hFF_FFFC;
`endif
      chk("ovf_i24", result_i24, e_ovf24);
      chk("ovf_q24", result_q24, 0);
      chk("ovf_i48", result_i, 48'h1FF_FFFC);
      @(posedge clk); #1 result_ready = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("ovf_done", seen, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
